// File: rtl/watchdog_pkg.sv
// -----------------------------------------------------------------------------
// watchdog_pkg
// Shared definitions for the watchdog timer core: the control FSM state
// encodings and the expiry-mode encodings. Imported by the core and its
// prescaler sub-module.
// -----------------------------------------------------------------------------
package watchdog_pkg;

    // Control FSM states. IDLE is the only state in which the core reports ready.
    typedef enum logic [1:0] {
        CTRL_IDLE   = 2'b00,
        CTRL_RUN    = 2'b01,
        CTRL_PAUSED = 2'b10
    } ctrl_state_e;

    // Behaviour when the watchdog counter runs out.
    typedef enum logic {
        MODE_ONESHOT    = 1'b0,
        MODE_AUTORELOAD = 1'b1
    } wd_mode_e;

endpackage : watchdog_pkg

// File: rtl/watchdog_prescaler.sv
// -----------------------------------------------------------------------------
// watchdog_prescaler
// Down-counting clock divider that produces one tick every init+1 enabled
// cycles. The tick is asserted combinationally in the enabled cycle where the
// count sits at zero; that same cycle reloads init, so the period follows the
// live value of init at every reload.
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (count cleared to 0)
//   load     : reload count from init (wins over enable)
//   enable   : advance the count this cycle
//   init     : reload value; tick period is init+1 cycles
//   tick     : high in the enabled cycle where the count is zero
// -----------------------------------------------------------------------------
module watchdog_prescaler
    import watchdog_pkg::*;
#(
    parameter int PRE_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 enable,
    input  logic [PRE_WIDTH-1:0] init,
    output logic                 tick
);

    logic [PRE_WIDTH-1:0] r_count;
    logic                 w_at_zero;

    assign w_at_zero = (r_count == '0);
    assign tick      = enable && w_at_zero;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of all others, independent of the
    // order in which the simulator evaluates the always blocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= init;
        end else if (enable) begin
            if (w_at_zero) begin
                r_count <= init;
            end else begin
                r_count <= r_count - PRE_WIDTH'(1);
            end
        end
    end

endmodule : watchdog_prescaler

// File: rtl/watchdog_timer_core.sv
// -----------------------------------------------------------------------------
// watchdog_timer_core
// Windowed watchdog timer. After start, the counter is decremented once per
// prescaler tick; reaching the end of count raises a one-cycle expired pulse
// and a sticky expired_flag, then either stops (one-shot) or reloads
// (auto-reload). A kick reloads the counter, but only inside the window
// (counter <= window_init); a kick outside it raises a one-cycle violation
// pulse instead. pause freezes both the counter and the prescaler.
//
// Ports
//   clk            : clock, rising edge
//   reset_n        : asynchronous active-low reset
//   prescaler_init : tick period minus one, in clk cycles
//   watchdog_init  : counter reload value, in ticks
//   window_init    : kick window threshold (>= watchdog_init disables checking)
//   mode           : 0 one-shot, 1 auto-reload
//   start          : strobe, IDLE -> RUN when watchdog_init != 0
//   stop           : strobe, RUN/PAUSED -> IDLE (counter value held)
//   kick           : strobe, reload request while RUN
//   pause          : level, freezes counting while high
//   curr_watchdog  : current counter value
//   ready          : high only in IDLE
//   expired        : registered one-cycle pulse on each expiry
//   violation      : registered one-cycle pulse on each early kick
//   expired_flag   : sticky expiry indicator, cleared by an accepted start
// -----------------------------------------------------------------------------
module watchdog_timer_core
    import watchdog_pkg::*;
#(
    parameter int CTR_WIDTH = 32,
    parameter int PRE_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PRE_WIDTH-1:0] prescaler_init,
    input  logic [CTR_WIDTH-1:0] watchdog_init,
    input  logic [CTR_WIDTH-1:0] window_init,
    input  logic                 mode,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 kick,
    input  logic                 pause,
    output logic [CTR_WIDTH-1:0] curr_watchdog,
    output logic                 ready,
    output logic                 expired,
    output logic                 violation,
    output logic                 expired_flag
);

    ctrl_state_e          r_state;
    ctrl_state_e          w_next_state;
    logic [CTR_WIDTH-1:0] r_counter;
    logic                 r_expired;
    logic                 r_violation;
    logic                 r_expired_flag;

    logic w_idle;
    logic w_active;
    logic w_start_ok;
    logic w_kick_cmd;
    logic w_kick_legal;
    logic w_kick_reload;
    logic w_kick_early;
    logic w_count_en;
    logic w_pre_load;
    logic w_tick;
    logic w_tick_eff;
    logic w_last_count;
    logic w_expire;
    logic w_autoreload;

    // ------------------------------------------------------------------
    // Command decode. stop outranks kick, which outranks the tick.
    // ------------------------------------------------------------------
    assign w_idle       = (r_state == CTRL_IDLE);
    assign w_active     = !w_idle;
    assign w_autoreload = (mode == MODE_AUTORELOAD);

    // A start with stop in the same cycle, or with a zero reload value, is dropped.
    assign w_start_ok   = w_idle && start && !stop && (watchdog_init != '0);

    // Kicks are honoured only in RUN; a kick arriving in PAUSED (including the
    // cycle that resumes from PAUSED) is ignored.
    assign w_kick_cmd   = (r_state == CTRL_RUN) && kick && !stop;

    // A window at or above the reload value would accept any counter value,
    // so it doubles as the "window checking off" setting.
    assign w_kick_legal  = (window_init >= watchdog_init) || (r_counter <= window_init);
    assign w_kick_reload = w_kick_cmd && w_kick_legal;
    assign w_kick_early  = w_kick_cmd && !w_kick_legal;

    // Counting runs whenever the timer is armed and not held by pause. The
    // resume cycle out of PAUSED already counts, so a pause of N cycles delays
    // expiry by exactly N cycles.
    assign w_count_en   = w_active && !pause && !stop;
    assign w_pre_load   = w_start_ok || w_kick_reload;

    // An accepted kick consumes the tick of the same cycle (it reloads both
    // counters), so a kick on the final tick prevents expiry. A rejected kick
    // leaves the tick to proceed normally.
    assign w_tick_eff   = w_tick && !w_kick_reload;
    assign w_last_count = (r_counter == CTR_WIDTH'(1));
    assign w_expire     = w_tick_eff && w_last_count;

    watchdog_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_pre_load),
        .enable  (w_count_en),
        .init    (prescaler_init),
        .tick    (w_tick)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CTRL_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the next-state value is given a default before the case so that
    // every path assigns it; a missing branch would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            CTRL_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = CTRL_RUN;
                end
            end
            CTRL_RUN,
            CTRL_PAUSED: begin
                if (stop) begin
                    w_next_state = CTRL_IDLE;
                end else if (w_expire && !w_autoreload) begin
                    w_next_state = CTRL_IDLE;
                end else if (pause) begin
                    w_next_state = CTRL_PAUSED;
                end else begin
                    w_next_state = CTRL_RUN;
                end
            end
            default: begin
                w_next_state = CTRL_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog counter. Holds its value in IDLE (including after stop) and
    // never moves below zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_counter <= '0;
        end else if (w_pre_load) begin
            r_counter <= watchdog_init;
        end else if (w_tick_eff) begin
            if (w_last_count) begin
                r_counter <= w_autoreload ? watchdog_init : '0;
            end else if (r_counter != '0) begin
                r_counter <= r_counter - CTR_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Status pulses and sticky flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_expired      <= 1'b0;
            r_violation    <= 1'b0;
            r_expired_flag <= 1'b0;
        end else begin
            r_expired   <= w_expire;
            r_violation <= w_kick_early;
            if (w_start_ok) begin
                r_expired_flag <= 1'b0;
            end else if (w_expire) begin
                r_expired_flag <= 1'b1;
            end
        end
    end

    assign curr_watchdog = r_counter;
    assign ready         = w_idle;
    assign expired       = r_expired;
    assign violation     = r_violation;
    assign expired_flag  = r_expired_flag;

endmodule : watchdog_timer_core

// File: tb/tb_watchdog_timer_core.sv
// -----------------------------------------------------------------------------
// tb_watchdog_timer_core
// Directed bench for watchdog_timer_core. A cycle model of the timer's rules
// runs alongside the DUT and is compared on every falling clock edge; the
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_watchdog_timer_core;

    logic        clk;
    logic        reset_n;
    logic [31:0] prescaler_init;
    logic [31:0] watchdog_init;
    logic [31:0] window_init;
    logic        mode;
    logic        start;
    logic        stop;
    logic        kick;
    logic        pause;
    logic [31:0] curr_watchdog;
    logic        ready;
    logic        expired;
    logic        violation;
    logic        expired_flag;

    int n_checks = 0;
    int n_pass   = 0;

    watchdog_timer_core dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .prescaler_init (prescaler_init),
        .watchdog_init  (watchdog_init),
        .window_init    (window_init),
        .mode           (mode),
        .start          (start),
        .stop           (stop),
        .kick           (kick),
        .pause          (pause),
        .curr_watchdog  (curr_watchdog),
        .ready          (ready),
        .expired        (expired),
        .violation      (violation),
        .expired_flag   (expired_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: armed/paused flags, tick countdown and counter, with
    // each rule applied in its priority order once per rising edge.
    // ------------------------------------------------------------------
    bit          m_run  = 1'b0;
    bit          m_pau  = 1'b0;
    logic [31:0] m_cnt  = '0;
    logic [31:0] m_pre  = '0;
    bit          m_exp  = 1'b0;
    bit          m_vio  = 1'b0;
    bit          m_flag = 1'b0;

    always @(posedge clk or negedge reset_n) begin : model
        bit          n_run, n_pau, n_exp, n_vio, n_flag, kick_ok;
        logic [31:0] n_cnt, n_pre;
        if (!reset_n) begin
            m_run  <= 1'b0;
            m_pau  <= 1'b0;
            m_cnt  <= '0;
            m_pre  <= '0;
            m_exp  <= 1'b0;
            m_vio  <= 1'b0;
            m_flag <= 1'b0;
        end else begin
            n_run = m_run; n_pau = m_pau; n_cnt = m_cnt; n_pre = m_pre;
            n_exp = 1'b0;  n_vio = 1'b0;  n_flag = m_flag;
            if (!m_run) begin
                if (start && !stop && watchdog_init != 0) begin
                    n_run = 1'b1; n_pau = 1'b0; n_flag = 1'b0;
                    n_cnt = watchdog_init; n_pre = prescaler_init;
                end
            end else if (stop) begin
                n_run = 1'b0; n_pau = 1'b0;
            end else begin
                kick_ok = kick && !m_pau;
                if (kick_ok && (window_init >= watchdog_init || m_cnt <= window_init)) begin
                    n_cnt = watchdog_init; n_pre = prescaler_init;
                end else begin
                    n_vio = kick_ok;
                    if (!pause) begin
                        if (m_pre == 0) begin
                            n_pre = prescaler_init;
                            if (m_cnt == 1) begin
                                n_exp = 1'b1; n_flag = 1'b1;
                                if (mode) n_cnt = watchdog_init;
                                else begin n_cnt = 0; n_run = 1'b0; end
                            end else if (m_cnt > 1) begin
                                n_cnt = m_cnt - 1;
                            end
                        end else begin
                            n_pre = m_pre - 1;
                        end
                    end
                end
                n_pau = n_run && pause;
            end
            m_run  <= n_run;
            m_pau  <= n_pau;
            m_cnt  <= n_cnt;
            m_pre  <= n_pre;
            m_exp  <= n_exp;
            m_vio  <= n_vio;
            m_flag <= n_flag;
        end
    end

    // Compare every cycle, mid-period.
    always @(negedge clk) begin
        check("cmp_curr",      curr_watchdog, m_cnt);
        check("cmp_ready",     ready,         !m_run);
        check("cmp_expired",   expired,       m_exp);
        check("cmp_violation", violation,     m_vio);
        check("cmp_flag",      expired_flag,  m_flag);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: every call leaves time at 1 ns after a rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setup(input int pre, input int wd, input int win, input bit md);
        prescaler_init = pre;
        watchdog_init  = wd;
        window_init    = win;
        mode           = md;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    task automatic pulse_kick();
        kick = 1'b1; step(1); kick = 1'b0;
    endtask

    initial begin
        int pulses;
        bit ready_seen;

        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; kick = 1'b0; pause = 1'b0;
        setup(0, 0, 0, 1'b0);

        #2;
        check("rst_ready",     ready,         1);
        check("rst_curr",      curr_watchdog, 0);
        check("rst_expired",   expired,       0);
        check("rst_violation", violation,     0);
        check("rst_flag",      expired_flag,  0);
        #10 reset_n = 1'b1;
        step(1);

        // start with a zero reload value is dropped; kick in IDLE does nothing
        setup(3, 0, 0, 1'b0);
        pulse_start();
        check("zero_init_ready", ready, 1);
        check("zero_init_curr",  curr_watchdog, 0);
        pulse_kick();
        check("idle_kick_vio", violation, 0);
        // stop together with start in IDLE stays in IDLE
        setup(3, 4, 4, 1'b0);
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        check("stop_start_ready", ready, 1);

        // one-shot: expiry 16 cycles after start
        setup(3, 4, 4, 1'b0);
        pulse_start();
        check("os_ready_run", ready, 0);
        check("os_curr_load", curr_watchdog, 4);
        step(15);
        check("os_curr_15",   curr_watchdog, 1);
        check("os_exp_15",    expired, 0);
        step(1);
        check("os_exp_16",    expired, 1);
        check("os_curr_16",   curr_watchdog, 0);
        check("os_ready_16",  ready, 1);
        check("os_flag_16",   expired_flag, 1);
        step(1);
        check("os_exp_17",    expired, 0);
        check("os_flag_17",   expired_flag, 1);

        // auto-reload: pulses every 16 cycles, never ready
        setup(3, 4, 4, 1'b1);
        pulse_start();
        check("ar_flag_clr", expired_flag, 0);
        pulses = 0; ready_seen = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step(1);
            if (expired) pulses++;
            if (ready) ready_seen = 1'b1;
            if (i == 16 || i == 32) begin
                check("ar_exp_pulse", expired, 1);
                check("ar_reload",    curr_watchdog, 4);
            end
        end
        check("ar_pulse_count", pulses, 2);
        check("ar_ready_low",   ready_seen, 0);
        // start while running is ignored
        watchdog_init = 7;
        pulse_start();
        check("run_start_ign", curr_watchdog, 4);
        pulse_stop();
        check("stop_ready", ready, 1);
        check("stop_hold",  curr_watchdog, 4);

        // window: early kick at counter 5
        setup(3, 8, 3, 1'b0);
        pulse_start();
        step(12);
        check("win_curr_5",  curr_watchdog, 5);
        pulse_kick();
        check("win_vio",     violation, 1);
        check("win_hold_5",  curr_watchdog, 5);
        step(1);
        check("win_vio_end", violation, 0);
        step(2);
        check("win_curr_4",  curr_watchdog, 4);
        // legal kick at counter 2
        step(8);
        check("win_curr_2",  curr_watchdog, 2);
        pulse_kick();
        check("kick_reload", curr_watchdog, 8);
        check("kick_no_vio", violation, 0);
        step(3);
        check("kick_pre_hold", curr_watchdog, 8);
        step(1);
        check("kick_pre_tick", curr_watchdog, 7);
        pulse_stop();

        // pause: counter frozen, expiry moved from cycle 5 to cycle 15
        setup(0, 5, 5, 1'b0);
        pulse_start();
        step(2);
        check("pause_curr_3", curr_watchdog, 3);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("pause_frozen", curr_watchdog, 3);
            check("pause_ready",  ready, 0);
        end
        pause = 1'b0;
        step(2);
        check("pause_curr_1", curr_watchdog, 1);
        check("pause_exp_14", expired, 0);
        step(1);
        check("pause_exp_15", expired, 1);
        check("pause_idle",   ready, 1);

        // kick on the final tick reloads and suppresses expiry
        setup(0, 3, 3, 1'b0);
        pulse_start();
        step(2);
        check("kt_curr_1", curr_watchdog, 1);
        pulse_kick();
        check("kt_reload", curr_watchdog, 3);
        check("kt_no_exp", expired, 0);
        check("kt_flag",   expired_flag, 0);
        step(1);
        check("kt_curr_2", curr_watchdog, 2);
        pulse_stop();

        // asynchronous reset mid-run, then start on first edge after release
        setup(0, 5, 5, 1'b0);
        pulse_start();
        step(2);
        check("ar_mid_curr", curr_watchdog, 3);
        #2 reset_n = 1'b0;
        #1;
        check("arst_ready", ready, 1);
        check("arst_curr",  curr_watchdog, 0);
        check("arst_exp",   expired, 0);
        step(1);
        check("arst_exp_hold", expired, 0);
        #2 reset_n = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("post_rst_start", ready, 0);
        check("post_rst_curr",  curr_watchdog, 5);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_watchdog_timer_core
